// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand class encoding and
// format-dependent bit patterns usable for any EXP_W/MAN_W.
package fp_pkg;

    // Widest format the pattern helpers can describe (sign + exponent + mantissa).
    localparam int FP_MAX_W = 128;

    typedef enum logic [2:0] {
        FP_ZERO   = 3'd0,
        FP_DENORM = 3'd1,
        FP_NORM   = 3'd2,
        FP_INF    = 3'd3,
        FP_QNAN   = 3'd4,
        FP_SNAN   = 3'd5
    } fp_class_e;

    // All-ones exponent field, right-aligned.
    function automatic logic [FP_MAX_W-1:0] exp_ones(input int exp_w);
        return (FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1);
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, mantissa MSB set, rest 0.
    function automatic logic [FP_MAX_W-1:0] canonical_qnan(input int exp_w, input int man_w);
        return ((FP_MAX_W'(1) << (exp_w + 1)) - FP_MAX_W'(1)) << (man_w - 1);
    endfunction

endpackage

// File: rtl/fp_mul_operand_classifier_classify.sv
// Combinational single-operand classifier (sign does not affect the class).
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_f,
    input  logic [MAN_W-1:0] man_f,
    output fp_class_e        cls
);

    // Decode exponent/mantissa into the class; mantissa MSB separates qNaN from sNaN.
    always_comb begin
        cls = FP_NORM;
        if (exp_f == '0) begin
            cls = (man_f == '0) ? FP_ZERO : FP_DENORM;
        end else if (&exp_f) begin
            if (man_f == '0) begin
                cls = FP_INF;
            end else if (man_f[MAN_W-1]) begin
                cls = FP_QNAN;
            end else begin
                cls = FP_SNAN;
            end
        end
    end

endmodule

// File: rtl/fp_mul_operand_classifier.sv
// Front end of a floating-point multiplier: classifies both operands,
// resolves special-case products in a two-stage valid/ready pipeline and
// counts invalid-operation results with a saturating counter.
module fp_mul_operand_classifier
    import fp_pkg::*;
#(
    parameter int  EXP_W         = 8,
    parameter int  MAN_W         = 23,
    parameter bit  PROPAGATE_NAN = 1'b0,
    parameter int  CNT_W         = 16,
    localparam int WIDTH         = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       class_a,
    output logic [2:0]       class_b,
    output logic             res_sign,
    output logic             special,
    output logic [WIDTH-1:0] special_res,
    output logic             flag_invalid,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] inv_cnt
);

    localparam logic [FP_MAX_W-1:0] EXP_ONES_WIDE = exp_ones(EXP_W);
    localparam logic [FP_MAX_W-1:0] QNAN_WIDE     = canonical_qnan(EXP_W, MAN_W);
    localparam logic [EXP_W-1:0]    EXP_ONES      = EXP_ONES_WIDE[EXP_W-1:0];
    localparam logic [WIDTH-1:0]    QNAN          = QNAN_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    QUIET_BIT     = WIDTH'(1) << (MAN_W - 1);

    // Stage 1: raw operands plus their classes
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    fp_class_e        s1_cls_a_reg;
    fp_class_e        s1_cls_b_reg;

    // Stage 2: resolved result (drives the outputs directly)
    logic             s2_valid_reg;
    logic [2:0]       class_a_reg;
    logic [2:0]       class_b_reg;
    logic             res_sign_reg;
    logic             special_reg;
    logic [WIDTH-1:0] special_res_reg;
    logic             flag_invalid_reg;
    logic [CNT_W-1:0] inv_cnt_reg;

    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;

    logic             res_sign_next;
    logic             special_next;
    logic [WIDTH-1:0] special_res_next;
    logic             flag_invalid_next;

    logic [WIDTH-1:0] op_arr [2];
    fp_class_e        cls_arr [2];

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign out_hs   = s2_valid_reg && out_ready;

    assign op_arr[0] = op_a;
    assign op_arr[1] = op_b;

    // One classifier per operand
    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
        fp_classify #(
            .EXP_W(EXP_W),
            .MAN_W(MAN_W)
        ) u_cls (
            .exp_f(op_arr[gi][WIDTH-2:MAN_W]),
            .man_f(op_arr[gi][MAN_W-1:0]),
            .cls  (cls_arr[gi])
        );
    end

    // Stage 1 register: capture operands and classes on an input handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_cls_a_reg <= FP_ZERO;
            s1_cls_b_reg <= FP_ZERO;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg     <= op_a;
                s1_b_reg     <= op_b;
                s1_cls_a_reg <= cls_arr[0];
                s1_cls_b_reg <= cls_arr[1];
            end
        end
    end

    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    assign a_snan = (s1_cls_a_reg == FP_SNAN);
    assign b_snan = (s1_cls_b_reg == FP_SNAN);
    assign a_nan  = a_snan || (s1_cls_a_reg == FP_QNAN);
    assign b_nan  = b_snan || (s1_cls_b_reg == FP_QNAN);
    assign a_inf  = (s1_cls_a_reg == FP_INF);
    assign b_inf  = (s1_cls_b_reg == FP_INF);
    assign a_zero = (s1_cls_a_reg == FP_ZERO);
    assign b_zero = (s1_cls_b_reg == FP_ZERO);

    // Special-case resolution in priority order: NaN, Inf*0, Inf, zero
    always_comb begin
        res_sign_next     = s1_a_reg[WIDTH-1] ^ s1_b_reg[WIDTH-1];
        special_next      = 1'b0;
        special_res_next  = '0;
        flag_invalid_next = 1'b0;
        if (a_nan || b_nan) begin
            special_next      = 1'b1;
            flag_invalid_next = a_snan || b_snan;
            if (PROPAGATE_NAN) begin
                special_res_next = (a_nan ? s1_a_reg : s1_b_reg) | QUIET_BIT;
            end else begin
                special_res_next = QNAN;
            end
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            special_next      = 1'b1;
            special_res_next  = QNAN;
            flag_invalid_next = 1'b1;
        end else if (a_inf || b_inf) begin
            special_next     = 1'b1;
            special_res_next = {res_sign_next, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            special_next     = 1'b1;
            special_res_next = {res_sign_next, {(WIDTH-1){1'b0}}};
        end
    end

    // Stage 2 register: hold the resolved result until downstream accepts it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg     <= 1'b0;
            class_a_reg      <= 3'd0;
            class_b_reg      <= 3'd0;
            res_sign_reg     <= 1'b0;
            special_reg      <= 1'b0;
            special_res_reg  <= '0;
            flag_invalid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                class_a_reg      <= s1_cls_a_reg;
                class_b_reg      <= s1_cls_b_reg;
                res_sign_reg     <= res_sign_next;
                special_reg      <= special_next;
                special_res_reg  <= special_res_next;
                flag_invalid_reg <= flag_invalid_next;
            end
        end
    end

    // Saturating invalid-result counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv_cnt_reg <= '0;
        end else if (cnt_clr) begin
            inv_cnt_reg <= '0;
        end else if (out_hs && flag_invalid_reg && !(&inv_cnt_reg)) begin
            inv_cnt_reg <= inv_cnt_reg + CNT_W'(1);
        end
    end

    assign out_valid    = s2_valid_reg;
    assign class_a      = class_a_reg;
    assign class_b      = class_b_reg;
    assign res_sign     = res_sign_reg;
    assign special      = special_reg;
    assign special_res  = special_res_reg;
    assign flag_invalid = flag_invalid_reg;
    assign inv_cnt      = inv_cnt_reg;

endmodule

// File: tb/tb_fp_mul_operand_classifier.sv
// Bench for fp_mul_operand_classifier: two single-precision instances
// (canonical-NaN with a 2-bit counter, NaN-propagating with a 16-bit counter)
// share the same stimulus and are checked against a reference model.
module tb_fp_mul_operand_classifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] op_a, op_b;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready0, out_valid0, res_sign0, special0, flag_invalid0;
    logic [2:0]  class_a0, class_b0;
    logic [31:0] special_res0;
    logic [1:0]  inv_cnt0;
    logic        in_ready1, out_valid1, res_sign1, special1, flag_invalid1;
    logic [2:0]  class_a1, class_b1;
    logic [31:0] special_res1;
    logic [15:0] inv_cnt1;

    always #5 clk = ~clk;

    fp_mul_operand_classifier #(.EXP_W(8), .MAN_W(23), .PROPAGATE_NAN(1'b0), .CNT_W(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid0), .out_ready(out_ready),
        .class_a(class_a0), .class_b(class_b0), .res_sign(res_sign0), .special(special0),
        .special_res(special_res0), .flag_invalid(flag_invalid0), .cnt_clr(cnt_clr),
        .inv_cnt(inv_cnt0));

    fp_mul_operand_classifier #(.EXP_W(8), .MAN_W(23), .PROPAGATE_NAN(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid1), .out_ready(out_ready),
        .class_a(class_a1), .class_b(class_b1), .res_sign(res_sign1), .special(special1),
        .special_res(special_res1), .flag_invalid(flag_invalid1), .cnt_clr(cnt_clr),
        .inv_cnt(inv_cnt1));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  ca, cb;
        logic        s, sp;
        logic [31:0] r0, r1;
        logic        fl;
    } res_t;

    function automatic logic [2:0] ref_class(input logic [31:0] x);
        int e = int'(x[30:23]);
        int m = int'(x[22:0]);
        if (e == 0)   return (m == 0) ? 3'd0 : 3'd1;
        if (e != 255) return 3'd2;
        if (m == 0)   return 3'd3;
        return (m >= 32'h400000) ? 3'd4 : 3'd5;
    endfunction

    function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        bit nan_a, nan_b;
        r.ca = ref_class(a);
        r.cb = ref_class(b);
        r.s  = a[31] ^ b[31];
        r.sp = 1'b1;
        r.fl = 1'b0;
        nan_a = (r.ca >= 3'd4);
        nan_b = (r.cb >= 3'd4);
        if (nan_a || nan_b) begin
            r.r0 = 32'h7FC00000;
            r.r1 = (nan_a ? a : b) | 32'h00400000;
            r.fl = (r.ca == 3'd5) || (r.cb == 3'd5);
        end else if ((r.ca == 3'd3 && r.cb == 3'd0) || (r.ca == 3'd0 && r.cb == 3'd3)) begin
            r.r0 = 32'h7FC00000;
            r.r1 = 32'h7FC00000;
            r.fl = 1'b1;
        end else if (r.ca == 3'd3 || r.cb == 3'd3) begin
            r.r0 = r.s ? 32'hFF800000 : 32'h7F800000;
            r.r1 = r.r0;
        end else if (r.ca == 3'd0 || r.cb == 3'd0) begin
            r.r0 = r.s ? 32'h80000000 : 32'h00000000;
            r.r1 = r.r0;
        end else begin
            r.sp = 1'b0;
            r.r0 = 32'h0;
            r.r1 = 32'h0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] s = 32'($urandom_range(0, 1)) << 31;
        case ($urandom_range(0, 5))
            0: return s;
            1: return s | 32'($urandom_range(1, 32'h7FFFFF));
            2: return s | 32'h7F800000;
            3: return s | 32'h7FC00000 | 32'($urandom_range(0, 32'h3FFFFF));
            4: return s | 32'h7F800000 | 32'($urandom_range(1, 32'h3FFFFF));
            default: return s | (32'($urandom_range(1, 254)) << 23) | 32'($urandom_range(0, 32'h7FFFFF));
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    typedef struct { logic [31:0] a, b; } pair_t;
    pair_t       sb_q[$];
    bit          mon_en = 1'b0;
    int          cnt0_m = 0, cnt1_m = 0;
    bit          held = 1'b0;
    logic [31:0] held_res;
    logic [2:0]  held_ca;
    logic        held_fl;
    int          txn_n = 0;
    pair_t       mp;
    res_t        me;

    // Sample at negedge: handshakes seen here complete at the next posedge
    always @(negedge clk) begin
        if (mon_en) begin
            chk("inv_cnt0", 64'(inv_cnt0), 64'(cnt0_m));
            chk("inv_cnt1", 64'(inv_cnt1), 64'(cnt1_m));
            if (held && out_valid0) begin
                chk("hold_res", 64'(special_res0), 64'(held_res));
                chk("hold_cls", 64'(class_a0), 64'(held_ca));
                chk("hold_flag", 64'(flag_invalid0), 64'(held_fl));
            end
            if (out_valid0 && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow actual=out_valid required=no_pending_result");
                end else begin
                    mp = sb_q.pop_front();
                    me = ref_model(mp.a, mp.b);
                    chk("class_a", 64'(class_a0), 64'(me.ca));
                    chk("class_b", 64'(class_b0), 64'(me.cb));
                    chk("res_sign", 64'(res_sign0), 64'(me.s));
                    chk("special", 64'(special0), 64'(me.sp));
                    chk("special_res0", 64'(special_res0), 64'(me.r0));
                    chk("special_res1", 64'(special_res1), 64'(me.r1));
                    chk("flag_invalid0", 64'(flag_invalid0), 64'(me.fl));
                    chk("flag_invalid1", 64'(flag_invalid1), 64'(me.fl));
                    chk("out_valid1", 64'(out_valid1), 64'(1));
                    $display("txn %0d a=%08h b=%08h cls=%0d/%0d sp=%0b res0=%08h res1=%08h inv=%0b",
                             txn_n, mp.a, mp.b, class_a0, class_b0, special0,
                             special_res0, special_res1, flag_invalid0);
                    txn_n++;
                    if (!cnt_clr && me.fl) begin
                        if (cnt0_m < 3) cnt0_m++;
                        if (cnt1_m < 65535) cnt1_m++;
                    end
                end
            end
            if (cnt_clr) begin
                cnt0_m = 0;
                cnt1_m = 0;
            end
            if (in_valid && in_ready0) sb_q.push_back('{op_a, op_b});
            held     = out_valid0 && !out_ready;
            held_res = special_res0;
            held_ca  = class_a0;
            held_fl  = flag_invalid0;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  ca, cb;
        logic        s, sp;
        logic [31:0] r0, r1;
        logic        fl;
    } vec_t;
    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        vecs[0] = '{32'h3F800000, 32'h7F800000, 3'd2, 3'd3, 1'b0, 1'b1, 32'h7F800000, 32'h7F800000, 1'b0};
        vecs[1] = '{32'h80000000, 32'h00000001, 3'd0, 3'd1, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b0};
        vecs[2] = '{32'h3FC00000, 32'h40000000, 3'd2, 3'd2, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0};
        vecs[3] = '{32'h7F800000, 32'h00000000, 3'd3, 3'd0, 1'b0, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b1};
        vecs[4] = '{32'h3F800000, 32'h7F800001, 3'd2, 3'd5, 1'b0, 1'b1, 32'h7FC00000, 32'h7FC00001, 1'b1};
        vecs[5] = '{32'hFFC00005, 32'h7F800001, 3'd4, 3'd5, 1'b1, 1'b1, 32'h7FC00000, 32'hFFC00005, 1'b1};
        vecs[6] = '{32'h00000000, 32'hFF800000, 3'd0, 3'd3, 1'b1, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b1};
        vecs[7] = '{32'hFF800000, 32'h3F800000, 3'd3, 3'd2, 1'b1, 1'b1, 32'hFF800000, 32'hFF800000, 1'b0};
        vecs[8] = '{32'h00400000, 32'h80000000, 3'd1, 3'd0, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready0), 64'(0));
        chk("rst_out_valid", 64'(out_valid0), 64'(0));
        chk("rst_special_res", 64'(special_res0), 64'(0));
        chk("rst_class_a", 64'(class_a0), 64'(0));
        chk("rst_inv_cnt", 64'(inv_cnt1), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready0), 64'(1));
        mon_en = 1'b1;

        // Table: one pair at a time, result checked two cycles after acceptance
        for (int i = 0; i < 9; i++) begin
            tick();
            in_valid = 1'b1; op_a = vecs[i].a; op_b = vecs[i].b;
            tick();
            in_valid = 1'b0;
            tick();
            chk("vec_out_valid", 64'(out_valid0), 64'(1));
            chk("vec_class_a", 64'(class_a0), 64'(vecs[i].ca));
            chk("vec_class_b", 64'(class_b0), 64'(vecs[i].cb));
            chk("vec_res_sign", 64'(res_sign0), 64'(vecs[i].s));
            chk("vec_special", 64'(special0), 64'(vecs[i].sp));
            chk("vec_res0", 64'(special_res0), 64'(vecs[i].r0));
            chk("vec_res1", 64'(special_res1), 64'(vecs[i].r1));
            chk("vec_flag", 64'(flag_invalid0), 64'(vecs[i].fl));
        end
        tick();

        // Saturation: clear, then 5 invalid results
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr_cnt0", 64'(inv_cnt0), 64'(0));
        in_valid = 1'b1; op_a = 32'h7F800000; op_b = 32'h0;
        repeat (5) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("sat_cnt0", 64'(inv_cnt0), 64'(3));
        chk("sat_cnt1", 64'(inv_cnt1), 64'(5));

        // Clear coinciding with an invalid output handshake
        in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
        chk("clr_hs_flag", 64'(flag_invalid0), 64'(1));
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr_hs_cnt0", 64'(inv_cnt0), 64'(0));
        chk("clr_hs_cnt1", 64'(inv_cnt1), 64'(0));

        // Backpressure: 3 back-to-back pairs with the output stalled
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6 && idx < 3; c++) begin
            in_valid = 1'b1; op_a = vecs[idx + 1].a; op_b = vecs[idx + 1].b;
            @(negedge clk);
            if (in_ready0) idx++;
            tick();
        end
        chk("bp_accepted", 64'(idx), 64'(2));
        chk("bp_in_ready", 64'(in_ready0), 64'(0));
        chk("bp_out_valid", 64'(out_valid0), 64'(1));
        chk("bp_head_res", 64'(special_res0), 64'(vecs[1].r0));
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            in_valid = 1'b1; op_a = vecs[idx + 1].a; op_b = vecs[idx + 1].b;
            @(negedge clk);
            if (in_ready0) idx++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'(3));
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick();
        chk("bp_drained", 64'(sb_q.size()), 64'(0));

        // Randomized traffic with random backpressure and occasional clears
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 40) == 0);
            op_a      = rand_op();
            op_b      = rand_op();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick();
        chk("rand_drained", 64'(sb_q.size()), 64'(0));

        // Reset mid-stream with invalid results counted and data in flight
        in_valid = 1'b1; op_a = 32'h7F800001; op_b = 32'h3F800000;
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (2) tick();
        mon_en = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", 64'(out_valid0), 64'(0));
        chk("mid_rst_cnt0", 64'(inv_cnt0), 64'(0));
        chk("mid_rst_cnt1", 64'(inv_cnt1), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready0), 64'(0));
        chk("mid_rst_res", 64'(special_res0), 64'(0));
        in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        sb_q.delete();
        cnt0_m = 0; cnt1_m = 0; held = 1'b0;
        #1;
        chk("mid_rst_in_ready_after", 64'(in_ready0), 64'(1));
        mon_en = 1'b1;

        // Operation resumes cleanly after reset
        in_valid = 1'b1; op_a = vecs[3].a; op_b = vecs[3].b;
        tick();
        in_valid = 1'b0;
        tick();
        chk("resume_res", 64'(special_res0), 64'(vecs[3].r0));
        for (int c = 0; c < 5; c++) tick();
        chk("resume_cnt1", 64'(inv_cnt1), 64'(1));
        chk("resume_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_operand_classifier.md
Name: fp_mul_operand_classifier

Overview:
- Parametrised successor to the single-operand IEEE-754 classifier.
- Classifies both operands of a floating-point multiply for any EXP_W/MAN_W format (half, single, double, custom).
- Separates quiet and signalling NaN, and resolves the special-case product (NaN/Inf/zero/invalid) ahead of the mantissa datapath.
- Two-stage valid/ready pipeline at the front of the real multiplier, plus a saturating invalid-operation event counter.

Parameters:
EXP_W, 8, exponent field width (11 for double, 5 for half)
MAN_W, 23, stored mantissa width (52 for double, 10 for half)
WIDTH, 1+EXP_W+MAN_W, operand width; derived, not overridden
PROPAGATE_NAN, 0, 0 = NaN result is canonical qNaN; 1 = quieted first NaN operand (a before b)
CNT_W, 16, invalid-event counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts pair this cycle
op_a  in  WIDTH  operand A
op_b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
class_a  out  3  class of A (package encoding)
class_b  out  3  class of B
res_sign  out  1  sign(A) xor sign(B), always valid
special  out  1  product fully determined by special_res
special_res  out  WIDTH  special-case product; 0 when special=0
flag_invalid  out  1  invalid operation (sNaN input or Inf*0)
cnt_clr  in  1  synchronous clear of inv_cnt
inv_cnt  out  CNT_W  saturating count of accepted results with flag_invalid=1

Behaviour:
- Classes: ZERO=0, DENORM=1, NORM=2, INF=3, QNAN=4, SNAN=5.
  - NORM: exponent != 0 and exponent != all-ones.
  - NaN: exponent all-ones, mantissa != 0. Mantissa MSB = 1 -> QNAN, else SNAN.
- Stage 1 registers the raw operands and both classes. Stage 2 registers the resolved result.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput 1 pair/cycle.
- Handshakes:
  - Input handshake = in_valid & in_ready. Output handshake = out_valid & out_ready.
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advance condition, combinational from out_ready, forced 0 while rst_n=0.
  - A stalled stage holds its data. Outputs stay stable while out_valid=1 and out_ready=0.
- Resolution, in priority order:
  1. Any NaN: special=1. PROPAGATE_NAN=0 -> canonical qNaN {0, all-ones, 1, zeros}. PROPAGATE_NAN=1 -> first NaN operand with mantissa MSB forced to 1. flag_invalid = either operand SNAN.
  2. INF with ZERO (either order): canonical qNaN, special=1, flag_invalid=1.
  3. Any INF: {res_sign, all-ones, 0}, special=1.
  4. Any ZERO: {res_sign, 0, 0}, special=1.
  5. Otherwise special=0, special_res=0, flag_invalid=0.
- Counter:
  - inv_cnt increments on an output handshake with flag_invalid=1 and saturates at all-ones.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset (rst_n=0 at a clk edge): both valid bits, out_valid, class_a/b, res_sign, special, special_res, flag_invalid and inv_cnt go to 0. In-flight data is discarded. in_ready=0 during reset and 1 on the first cycle after.

Decomposition:
- Package fp_pkg holds:
  - class enum/localparams (ZERO..SNAN)
  - functions or constants for the all-ones exponent and canonical qNaN, parametrised by EXP_W/MAN_W
- One sub-module fp_classify (combinational, single operand -> 3-bit class), instantiated twice in stage 1.
- Pipeline control, resolution and counter live in the top module.

Test Plan:
- Single precision, A=0x3F800000, B=0x7F800000, out_ready=1 -> 2 cycles later: class_a=2, class_b=3, special=1, special_res=0x7F800000, flag_invalid=0.
- A=0x80000000, B=0x00000001 -> class_a=0, class_b=1, res_sign=1, special_res=0x80000000. Then A=0x3FC00000, B=0x40000000 -> special=0, special_res=0.
- A=0x7F800000, B=0x00000000 -> special_res=0x7FC00000, flag_invalid=1, inv_cnt 0->1 after handshake.
- PROPAGATE_NAN=1: A=0x3F800000, B=0x7F800001 -> class_b=5, special_res=0x7FC00001, flag_invalid=1. With PROPAGATE_NAN=0 the same pair -> 0x7FC00000.
- Backpressure: out_ready=0, push 3 back-to-back pairs -> in_ready drops after 2 are accepted, outputs hold. Raise out_ready -> results drain in order with no loss or duplication.
- CNT_W=2: 5 invalid results -> inv_cnt saturates at 3. cnt_clr asserted together with an invalid handshake -> inv_cnt=0. rst_n low mid-stream -> out_valid=0 and inv_cnt=0 on the next cycle.
